// File: rtl/pin_debounce.sv
// Two-flop synchroniser plus per-transition stability debouncer with edge strobes.
// Optional saturating glitch counter enabled by PIN_DEBOUNCE_GLITCH_CNT_EN.
module pin_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Pin,
  output logic       Pout,
  output logic       Rise,
  output logic       Fall
`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] GlitchCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE_LO,
    CHK_HI,
    IDLE_HI,
    CHK_LO
  } state_t;

  localparam logic [CNT_W-1:0] L_DEB = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);
  localparam bit               L_IMM = (DEB_CYCLES == 1);

  logic             r_q1;
  logic             r_q2;
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_pout;
  logic             r_rise;
  logic             r_fall;

  state_t           w_state_n;
  logic [CNT_W-1:0] w_count_n;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_pout_n;
  logic             w_rise_n;
  logic             w_fall_n;
  logic             w_s;

  assign w_s       = r_q2;
  assign w_cnt_inc = r_count + L_ONE;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_q1    <= 1'b0;
      r_q2    <= 1'b0;
      r_state <= IDLE_LO;
      r_count <= '0;
      r_pout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_q1    <= Pin;
      r_q2    <= r_q1;
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_pout  <= w_pout_n;
      r_rise  <= w_rise_n;
      r_fall  <= w_fall_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_pout_n  = r_pout;
    w_rise_n  = 1'b0;
    w_fall_n  = 1'b0;
    unique case (r_state)
      IDLE_LO: begin
        if (w_s) begin
          if (L_IMM) begin
            w_state_n = IDLE_HI;
            w_pout_n  = 1'b1;
            w_rise_n  = 1'b1;
            w_count_n = '0;
          end else begin
            w_state_n = CHK_HI;
            w_count_n = L_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!w_s) begin
          w_state_n = IDLE_LO;
          w_count_n = '0;
        end else if (w_cnt_inc == L_DEB) begin
          w_state_n = IDLE_HI;
          w_pout_n  = 1'b1;
          w_rise_n  = 1'b1;
          w_count_n = '0;
        end else begin
          w_count_n = w_cnt_inc;
        end
      end
      IDLE_HI: begin
        if (!w_s) begin
          if (L_IMM) begin
            w_state_n = IDLE_LO;
            w_pout_n  = 1'b0;
            w_fall_n  = 1'b1;
            w_count_n = '0;
          end else begin
            w_state_n = CHK_LO;
            w_count_n = L_ONE;
          end
        end
      end
      CHK_LO: begin
        if (w_s) begin
          w_state_n = IDLE_HI;
          w_count_n = '0;
        end else if (w_cnt_inc == L_DEB) begin
          w_state_n = IDLE_LO;
          w_pout_n  = 1'b0;
          w_fall_n  = 1'b1;
          w_count_n = '0;
        end else begin
          w_count_n = w_cnt_inc;
        end
      end
      default: begin
        w_state_n = IDLE_LO;
        w_count_n = '0;
      end
    endcase
  end

  assign Pout = r_pout;
  assign Rise = r_rise;
  assign Fall = r_fall;

`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] r_glitch;
  logic       w_abort;

  // An abort is a check state seeing the level it started from.
  assign w_abort = ((r_state == CHK_HI) && !w_s) ||
                   ((r_state == CHK_LO) && w_s);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_glitch <= '0;
    end else if (w_abort && (r_glitch != 8'hFF)) begin
      r_glitch <= r_glitch + 8'd1;
    end
  end

  assign GlitchCnt = r_glitch;
`else
  // No glitch counter in this build.
`endif

endmodule

// File: tb/tb_pin_debounce.sv
// Directed bench for pin_debounce with DEB_CYCLES=4, CNT_W=3.
// Define PIN_DEBOUNCE_GLITCH_CNT_EN to also check the glitch counter.
module tb_pin_debounce;

  localparam int DEB   = 4;
  localparam int CNT_W = 3;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  logic Pin   = 1'b0;
  logic Pout;
  logic Rise;
  logic Fall;
`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] GlitchCnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_glitch = 0;

  pin_debounce #(
    .DEB_CYCLES(DEB),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Pin      (Pin),
    .Pout     (Pout),
    .Rise     (Rise),
    .Fall     (Fall)
`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
    ,
    .GlitchCnt(GlitchCnt)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    Pin   = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_out got=%b exp=000", {Pout, Rise, Fall});
    end
`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (GlitchCnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_glitch got=%0d exp=0", GlitchCnt);
    end
`endif
    Rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL post_reset got=%b exp=000", {Pout, Rise, Fall});
    end
  endtask

  task automatic test_clean_rise;
    Pin = 1'b0;
    repeat (5) tick();
    Pin = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      n_cmp++;
      if ({Pout, Rise, Fall} !== 3'b000) begin
        n_bad++;
        $display("FAIL rise_wait e%0d got=%b exp=000", k, {Pout, Rise, Fall});
      end
    end
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b110) begin
      n_bad++;
      $display("FAIL rise_accept got=%b exp=110", {Pout, Rise, Fall});
    end
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b100) begin
      n_bad++;
      $display("FAIL rise_hold got=%b exp=100", {Pout, Rise, Fall});
    end
  endtask

  task automatic test_fall;
    Pin = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      tick();
      n_cmp++;
      if ({Pout, Rise, Fall} !== 3'b100) begin
        n_bad++;
        $display("FAIL fall_wait e%0d got=%b exp=100", k, {Pout, Rise, Fall});
      end
    end
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b001) begin
      n_bad++;
      $display("FAIL fall_accept got=%b exp=001", {Pout, Rise, Fall});
    end
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL fall_hold got=%b exp=000", {Pout, Rise, Fall});
    end
  endtask

  task automatic test_bounce_rise;
    int  nr;
    logic exp_p;
    nr = 0;
    for (int k = 0; k <= 12; k++) begin
      Pin = (k == 2) ? 1'b0 : 1'b1;
      tick();
      nr += int'(Rise);
      exp_p = (k >= 8);
      n_cmp++;
      if ({Pout, Fall} !== {exp_p, 1'b0}) begin
        n_bad++;
        $display("FAIL bounce_out e%0d got=%b exp=%b", k, {Pout, Fall}, {exp_p, 1'b0});
      end
    end
    n_cmp++;
    if (nr != 1) begin
      n_bad++;
      $display("FAIL bounce_rise_count got=%0d exp=1", nr);
    end
    exp_glitch++;
`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (GlitchCnt !== 8'(exp_glitch)) begin
      n_bad++;
      $display("FAIL bounce_glitch got=%0d exp=%0d", GlitchCnt, exp_glitch);
    end
`endif
    Pin = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL bounce_settle got=%b exp=000", {Pout, Rise, Fall});
    end
  endtask

  task automatic test_short_pulse;
    for (int k = 0; k <= 11; k++) begin
      Pin = (k < 3) ? 1'b1 : 1'b0;
      tick();
      n_cmp++;
      if ({Pout, Rise, Fall} !== 3'b000) begin
        n_bad++;
        $display("FAIL short_pulse e%0d got=%b exp=000", k, {Pout, Rise, Fall});
      end
    end
    exp_glitch++;
`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (GlitchCnt !== 8'(exp_glitch)) begin
      n_bad++;
      $display("FAIL short_glitch got=%0d exp=%0d", GlitchCnt, exp_glitch);
    end
`endif
  endtask

  task automatic test_reset_mid;
    Pin = 1'b1;
    repeat (3) tick();
    Rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_out got=%b exp=000", {Pout, Rise, Fall});
    end
    exp_glitch = 0;
`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (GlitchCnt !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst_glitch got=%0d exp=0", GlitchCnt);
    end
`endif
    Rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if ({Pout, Rise, Fall} !== 3'b000) begin
        n_bad++;
        $display("FAIL midrst_wait r%0d got=%b exp=000", k, {Pout, Rise, Fall});
      end
    end
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b110) begin
      n_bad++;
      $display("FAIL midrst_accept got=%b exp=110", {Pout, Rise, Fall});
    end
    tick();
    n_cmp++;
    if ({Pout, Rise, Fall} !== 3'b100) begin
      n_bad++;
      $display("FAIL midrst_hold got=%b exp=100", {Pout, Rise, Fall});
    end
  endtask

  task automatic test_saturation;
    int bad_out;
    Pin = 1'b0;
    repeat (10) tick();
    bad_out = 0;
    for (int g = 0; g < 300; g++) begin
      for (int k = 0; k < 4; k++) begin
        Pin = (k < 3) ? 1'b1 : 1'b0;
        tick();
        if ({Pout, Rise, Fall} !== 3'b000) bad_out++;
      end
      exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
    end
    repeat (4) tick();
    n_cmp++;
    if (bad_out != 0) begin
      n_bad++;
      $display("FAIL sat_out got=%0d bad cycles exp=0", bad_out);
    end
`ifdef PIN_DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (GlitchCnt !== 8'(exp_glitch)) begin
      n_bad++;
      $display("FAIL sat_glitch got=%0d exp=%0d", GlitchCnt, exp_glitch);
    end
    for (int g = 0; g < 3; g++) begin
      Pin = 1'b1;
      repeat (2) tick();
      Pin = 1'b0;
      repeat (4) tick();
    end
    n_cmp++;
    if (GlitchCnt !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_hold got=%0d exp=255", GlitchCnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_fall();
    test_bounce_rise();
    test_short_pulse();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
